// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: timing defaults, FSM state encoding and GRB word layout.
// Used by both the receiver and the transmitter.
package ws2812_pkg;

    localparam int unsigned T_MIN_HI_DEF = 8;
    localparam int unsigned T_THRESH_DEF = 30;
    localparam int unsigned T_MAX_HI_DEF = 55;
    localparam int unsigned T_RESET_DEF  = 2500;

    localparam int unsigned PIX_BITS = 24;
    localparam int unsigned MAX_PIX  = 64;

    // GRB wire order, MSB first: G occupies the top byte
    localparam int unsigned G_LSB = 16;
    localparam int unsigned R_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_t;

    typedef logic [PIX_BITS-1:0] grb_word_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic rgb_t grb_unpack(grb_word_t w);
        rgb_t c;
        c.g = w[G_LSB +: 8];
        c.r = w[R_LSB +: 8];
        c.b = w[B_LSB +: 8];
        return c;
    endfunction

    function automatic int unsigned cnt_width(int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Line conditioning for the WS2812 receiver: 2-flop synchronizer, edge detect,
// and consecutive high/low cycle counters.
module ws2812_pulse_meas
    import ws2812_pkg::*;
#(
    parameter int unsigned T_MAX_HI = T_MAX_HI_DEF,
    parameter int unsigned T_RESET  = T_RESET_DEF,
    localparam int unsigned HW = cnt_width(T_MAX_HI + 1),
    localparam int unsigned LW = cnt_width(T_RESET)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          led_din,
    output logic          rise,
    output logic          fall,
    output logic          too_long,
    output logic          lo_reset,
    output logic [HW-1:0] hi_cnt
);

    localparam logic [HW-1:0] HI_SAT  = HW'(T_MAX_HI + 1);
    localparam logic [HW-1:0] HI_MAX  = HW'(T_MAX_HI);
    localparam logic [LW-1:0] LO_SAT  = LW'(T_RESET);
    localparam logic [LW-1:0] LO_LAST = LW'(T_RESET - 1);

    logic [1:0]    sync_q;
    logic          din_s;
    logic          din_d;
    logic [LW-1:0] lo_cnt;

    assign din_s = sync_q[1];

    // hi_cnt counts completed high cycles and holds its value through the low
    // phase, so on the falling-edge cycle it equals the full pulse length.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            din_d  <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], led_din};
            din_d  <= din_s;
            if (din_s) begin
                lo_cnt <= '0;
                if (!din_d) begin
                    hi_cnt <= HW'(1);
                end else if (hi_cnt != HI_SAT) begin
                    hi_cnt <= hi_cnt + 1'b1;
                end
            end else if (lo_cnt != LO_SAT) begin
                lo_cnt <= lo_cnt + 1'b1;
            end
        end
    end

    assign rise     = din_s & ~din_d;
    assign fall     = ~din_s & din_d;
    assign too_long = din_s & din_d & (hi_cnt >= HI_MAX);
    // lo_cnt saturates, so this fires once per low run of T_RESET cycles
    assign lo_reset = ~din_s & (lo_cnt == LO_LAST);

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes GRB pixels, frame boundaries and protocol errors.
// Optional feature: define WS2812_RX_ERR_CNT_EN to add the saturating err_cnt output.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned T_MIN_HI = T_MIN_HI_DEF,
    parameter int unsigned T_THRESH = T_THRESH_DEF,
    parameter int unsigned T_MAX_HI = T_MAX_HI_DEF,
    parameter int unsigned T_RESET  = T_RESET_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       led_din,
    output logic       pix_valid,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b,
    output logic [5:0] pix_idx,
    output logic       frame_done,
    output logic       err
`ifdef WS2812_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned HW = cnt_width(T_MAX_HI + 1);
    localparam logic [HW-1:0] MIN_HI    = HW'(T_MIN_HI);
    localparam logic [HW-1:0] THRESH    = HW'(T_THRESH);
    localparam logic [4:0]    LAST_BIT  = 5'(PIX_BITS - 1);
    localparam logic [6:0]    PIX_LIMIT = 7'(MAX_PIX);

    logic          rise;
    logic          fall;
    logic          too_long;
    logic          lo_reset;
    logic [HW-1:0] hi_cnt;

    ws2812_pulse_meas #(
        .T_MAX_HI (T_MAX_HI),
        .T_RESET  (T_RESET)
    ) u_meas (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .led_din   (led_din),
        .rise      (rise),
        .fall      (fall),
        .too_long  (too_long),
        .lo_reset  (lo_reset),
        .hi_cnt    (hi_cnt)
    );

    rx_state_t state_q;
    rx_state_t state_d;

    logic            bit_take;
    logic            tim_err;
    logic            eof;
    logic            sync_exit;
    logic            err_set;
    logic            bit_val;
    logic            last_bit;
    grb_word_t       word_next;
    rgb_t            pix_rgb;

    logic [PIX_BITS-2:0] shreg;
    logic [4:0]          bit_cnt;
    logic [6:0]          pix_cnt;
    logic                got_bit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_take  = 1'b0;
        tim_err   = 1'b0;
        eof       = 1'b0;
        sync_exit = 1'b0;
        case (state_q)
            SYNC: begin
                if (lo_reset) begin
                    state_d   = IDLE;
                    sync_exit = 1'b1;
                end
            end
            IDLE: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (too_long) begin
                    tim_err = 1'b1;
                    state_d = SYNC;
                end else if (fall) begin
                    if (hi_cnt < MIN_HI) begin
                        tim_err = 1'b1;
                        state_d = SYNC;
                    end else begin
                        bit_take = 1'b1;
                        state_d  = LOW;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (lo_reset) begin
                    eof     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign bit_val   = (hi_cnt >= THRESH);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign word_next = {shreg, bit_val};
    assign pix_rgb   = grb_unpack(word_next);
    assign err_set   = tim_err
                     | (eof & (bit_cnt != 5'd0))
                     | (bit_take & last_bit & (pix_cnt == PIX_LIMIT));

    // pix_cnt runs to PIX_LIMIT+1 so only the first overflow pixel raises err
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            data_r     <= '0;
            data_g     <= '0;
            data_b     <= '0;
            pix_idx    <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            got_bit    <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= err_set;
            if (bit_take) begin
                shreg   <= word_next[PIX_BITS-2:0];
                got_bit <= 1'b1;
                if (last_bit) begin
                    bit_cnt <= '0;
                    if (pix_cnt < PIX_LIMIT) begin
                        data_r    <= pix_rgb.r;
                        data_g    <= pix_rgb.g;
                        data_b    <= pix_rgb.b;
                        pix_idx   <= pix_cnt[5:0];
                        pix_valid <= 1'b1;
                        pix_cnt   <= pix_cnt + 1'b1;
                    end else if (pix_cnt == PIX_LIMIT) begin
                        pix_cnt <= PIX_LIMIT + 7'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (tim_err) begin
                bit_cnt <= '0;
            end
            if (eof) begin
                frame_done <= got_bit;
                bit_cnt    <= '0;
                pix_cnt    <= '0;
                got_bit    <= 1'b0;
            end
            if (sync_exit) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
                got_bit <= 1'b0;
            end
        end
    end

`ifdef WS2812_RX_ERR_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt <= '0;
        end else if (err_set && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: table of directed pixels plus hand-written
// sequences for partial frames, timing errors, pixel overflow and async reset.
`timescale 1ns/1ps
module tb_ws2812_rx;
    import ws2812_pkg::*;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       led_din   = 1'b0;
    logic       pix_valid;
    logic [7:0] data_r;
    logic [7:0] data_g;
    logic [7:0] data_b;
    logic [5:0] pix_idx;
    logic       frame_done;
    logic       err;
`ifdef WS2812_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       ec_rst_n = 1'b0;
    logic       ec_din   = 1'b0;
    logic       ec_pv, ec_fd, ec_err;
    logic [7:0] ec_r, ec_g, ec_b, ec_cnt;
    logic [5:0] ec_idx;
`endif

    always #5 sys_clk = ~sys_clk;

    ws2812_rx #(
        .T_MIN_HI (8),
        .T_THRESH (30),
        .T_MAX_HI (55),
        .T_RESET  (2500)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .led_din    (led_din),
        .pix_valid  (pix_valid),
        .data_r     (data_r),
        .data_g     (data_g),
        .data_b     (data_b),
        .pix_idx    (pix_idx),
        .frame_done (frame_done),
        .err        (err)
`ifdef WS2812_RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

`ifdef WS2812_RX_ERR_CNT_EN
    ws2812_rx #(
        .T_RESET (16)
    ) dut_ec (
        .sys_clk    (sys_clk),
        .sys_rst_n  (ec_rst_n),
        .led_din    (ec_din),
        .pix_valid  (ec_pv),
        .data_r     (ec_r),
        .data_g     (ec_g),
        .data_b     (ec_b),
        .pix_idx    (ec_idx),
        .frame_done (ec_fd),
        .err        (ec_err),
        .err_cnt    (ec_cnt)
    );
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned cyc = 0, n_valid = 0, n_done = 0, n_err = 0;
    int unsigned err_cyc = 0, done_cyc = 0;
    int unsigned run_pv = 0, run_fd = 0, run_er = 0;
    int unsigned max_pv = 0, max_fd = 0, max_er = 0;
    logic [29:0] last_pix = '0;

    always @(posedge sys_clk) begin
        #1;
        cyc++;
        if (pix_valid) begin
            n_valid++;
            last_pix = {data_r, data_g, data_b, pix_idx};
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
        run_pv = pix_valid  ? run_pv + 1 : 0;
        run_fd = frame_done ? run_fd + 1 : 0;
        run_er = err        ? run_er + 1 : 0;
        if (run_pv > max_pv) max_pv = run_pv;
        if (run_fd > max_fd) max_fd = run_fd;
        if (run_er > max_er) max_er = run_er;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b, input int unsigned t0, input int unsigned t1,
                            input int unsigned per);
        int unsigned h;
        h = b ? t1 : t0;
        led_din = 1'b1;
        tick(h);
        led_din = 1'b0;
        tick(per - h);
    endtask

    task automatic send_pixel(input logic [23:0] w, input int unsigned nbits,
                              input int unsigned t0, input int unsigned t1,
                              input int unsigned per);
        for (int unsigned k = 0; k < nbits; k++) begin
            send_bit(w[23-k], t0, t1, per);
        end
    endtask

    typedef struct {
        logic [7:0]  g, r, b;
        int unsigned t0, t1;
        logic [7:0]  exp_r, exp_g, exp_b;
        logic [5:0]  exp_idx;
    } vec_t;

    vec_t vecs [4];

    localparam int unsigned LONG_LOW = 2510;

    initial begin
        int unsigned v0, d0, e0;

        // t0/t1 values exercise the min-legal, threshold and max-legal edges
        vecs[0] = '{g:8'h12, r:8'hAB, b:8'hCD, t0:20, t1:40,
                    exp_r:8'hAB, exp_g:8'h12, exp_b:8'hCD, exp_idx:6'd0};
        vecs[1] = '{g:8'hFF, r:8'h00, b:8'h5A, t0:8,  t1:30,
                    exp_r:8'h00, exp_g:8'hFF, exp_b:8'h5A, exp_idx:6'd1};
        vecs[2] = '{g:8'h80, r:8'h01, b:8'h7E, t0:29, t1:55,
                    exp_r:8'h01, exp_g:8'h80, exp_b:8'h7E, exp_idx:6'd2};
        vecs[3] = '{g:8'h00, r:8'hFF, b:8'h00, t0:20, t1:40,
                    exp_r:8'hFF, exp_g:8'h00, exp_b:8'h00, exp_idx:6'd3};

        tick(5);
        chk("reset_outputs", {2'b0, pix_valid, frame_done, err, data_r, data_g, data_b, pix_idx}, 32'h0);
        chk("reset_state", 32'(dut.state_q), 32'(SYNC));
        sys_rst_n = 1'b1;
        tick(LONG_LOW);
        chk("sync_to_idle", 32'(dut.state_q), 32'(IDLE));

        v0 = n_valid; d0 = n_done; e0 = n_err;
        for (int i = 0; i < 4; i++) begin
            int unsigned vb;
            vb = n_valid;
            send_pixel({vecs[i].g, vecs[i].r, vecs[i].b}, 24, vecs[i].t0, vecs[i].t1, 62);
            tick(4);
            chk($sformatf("vec%0d_count", i), n_valid - vb, 1);
            chk($sformatf("vec%0d_pixel", i), {2'b0, last_pix},
                {2'b0, vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_b, vecs[i].exp_idx});
        end
        tick(LONG_LOW);
        chk("frame1_valid", n_valid - v0, 4);
        chk("frame1_done", n_done - d0, 1);
        chk("frame1_err", n_err - e0, 0);

        // partial pixel then end of frame
        v0 = n_valid; d0 = n_done; e0 = n_err;
        send_pixel(24'hA5F00F, 12, 20, 40, 62);
        tick(LONG_LOW);
        chk("partial_err", n_err - e0, 1);
        chk("partial_done", n_done - d0, 1);
        chk("partial_valid", n_valid - v0, 0);
        chk("partial_same_cycle", err_cyc, done_cyc);
        send_pixel(24'h0FF033, 24, 20, 40, 62);
        tick(4);
        chk("after_partial_pixel", {2'b0, last_pix}, {2'b0, 8'hF0, 8'h0F, 8'h33, 6'd0});
        tick(LONG_LOW);

        // too-short high pulse
        e0 = n_err;
        led_din = 1'b1; tick(4); led_din = 1'b0; tick(10);
        chk("short_err", n_err - e0, 1);
        chk("short_state", 32'(dut.state_q), 32'(SYNC));
        tick(LONG_LOW);
        send_pixel(24'h55AA01, 24, 20, 40, 62);
        tick(4);
        chk("after_short_pixel", {2'b0, last_pix}, {2'b0, 8'hAA, 8'h55, 8'h01, 6'd0});
        tick(LONG_LOW);

        // too-long high pulse
        e0 = n_err;
        led_din = 1'b1; tick(60); led_din = 1'b0; tick(10);
        chk("long_err", n_err - e0, 1);
        chk("long_state", 32'(dut.state_q), 32'(SYNC));
        tick(LONG_LOW);
        send_pixel(24'hC33C99, 24, 20, 40, 62);
        tick(4);
        chk("after_long_pixel", {2'b0, last_pix}, {2'b0, 8'h3C, 8'hC3, 8'h99, 6'd0});
        tick(LONG_LOW);

        // 65 pixels in one frame
        v0 = n_valid; d0 = n_done; e0 = n_err;
        for (int p = 0; p < 65; p++) begin
            send_pixel(24'h000000, 24, 10, 30, 16);
        end
        tick(4);
        chk("overflow_valid", n_valid - v0, 64);
        chk("overflow_err", n_err - e0, 1);
        chk("overflow_last_idx", {2'b0, last_pix}, {2'b0, 24'h000000, 6'd63});
        tick(LONG_LOW);
        chk("overflow_done", n_done - d0, 1);
        chk("overflow_err_total", n_err - e0, 1);

        // asynchronous reset in the middle of a pixel
        send_pixel(24'h12ABCD, 24, 20, 40, 62);
        tick(4);
        chk("pre_reset_pixel", {2'b0, last_pix}, {2'b0, 8'hAB, 8'h12, 8'hCD, 6'd0});
        send_pixel(24'h345678, 10, 20, 40, 62);
        led_din = 1'b1;
        tick(5);
        #2;
        sys_rst_n = 1'b0;
        led_din   = 1'b0;
        #1;
        chk("async_reset_outputs", {2'b0, pix_valid, frame_done, err, data_r, data_g, data_b, pix_idx}, 32'h0);
        chk("async_reset_state", 32'(dut.state_q), 32'(SYNC));
        tick(3);
        sys_rst_n = 1'b1;
        tick(LONG_LOW);
        v0 = n_valid;
        send_pixel(24'h345678, 24, 20, 40, 62);
        tick(4);
        chk("post_reset_count", n_valid - v0, 1);
        chk("post_reset_pixel", {2'b0, last_pix}, {2'b0, 8'h56, 8'h34, 8'h78, 6'd0});
        tick(LONG_LOW);

        chk("pix_valid_width", max_pv, 1);
        chk("frame_done_width", max_fd, 1);
        chk("err_width", max_er, 1);

`ifdef WS2812_RX_ERR_CNT_EN
        chk("err_cnt_after_reset", {24'h0, err_cnt}, 32'd0);
        tick(2);
        ec_rst_n = 1'b1;
        tick(20);
        for (int n = 0; n < 300; n++) begin
            ec_din = 1'b1; tick(4);
            ec_din = 1'b0; tick(20);
        end
        chk("err_cnt_saturate", {24'h0, ec_cnt}, 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
